// File: rtl/loadstore.sv
// Load/store stage: forwards ALU results to write-back or runs a single
// pipelined Wishbone B4 transaction for loads and stores, one at a time.
module loadstore (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        input_ready_o,
    input  logic        input_valid_i,
    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic        ls_unsigned_load_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [3:0]  sel_q, sel_d, lsel_q, lsel_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d, uns_q, uns_d, rw_q, rw_d;
    logic [4:0]  ra_q, ra_d;
    logic        ov_q, ov_d, orw_q, orw_d;
    logic [4:0]  ora_q, ora_d;
    logic [31:0] odata_q, odata_d;
    logic        done;

    // Align the returned word to the requested byte lane, then size/extend.
    function automatic logic [31:0] load_extract(input logic [31:0] d,
                                                 input logic [1:0]  off,
                                                 input logic [3:0]  sel,
                                                 input logic        uns);
        logic [31:0] s;
        logic [31:0] r;
        s = d >> {off, 3'b000};
        case (sel)
            4'b0001: r = uns ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            4'b0011: r = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Ack only counts once the request has been accepted (stall low).
    assign done = ((state_q == REQUEST) && !wb_stall_i && wb_ack_i) ||
                  ((state_q == WAIT_ACK) && wb_ack_i);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        lsel_d  = lsel_q;
        off_d   = off_q;
        we_d    = we_q;
        uns_d   = uns_q;
        rw_d    = rw_q;
        ra_d    = ra_q;
        ov_d    = 1'b0;
        orw_d   = orw_q;
        ora_d   = ora_q;
        odata_d = odata_q;
        case (state_q)
            IDLE: begin
                if (input_valid_i) begin
                    if (ls_enable_i) begin
                        adr_d   = {result_i[31:2], 2'b00};
                        dat_d   = ls_write_data_i << {result_i[1:0], 3'b000};
                        sel_d   = ls_sel_i << result_i[1:0];
                        lsel_d  = ls_sel_i;
                        off_d   = result_i[1:0];
                        we_d    = ls_write_i;
                        uns_d   = ls_unsigned_load_i;
                        rw_d    = reg_write_i;
                        ra_d    = reg_addr_i;
                        state_d = REQUEST;
                    end else begin
                        ov_d    = 1'b1;
                        orw_d   = reg_write_i;
                        ora_d   = reg_addr_i;
                        odata_d = result_i;
                    end
                end
            end
            REQUEST: begin
                if (!wb_stall_i) state_d = wb_ack_i ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wb_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            ov_d    = 1'b1;
            orw_d   = rw_q;
            ora_d   = ra_q;
            odata_d = we_q ? 32'b0 : load_extract(wb_dat_i, off_q, lsel_q, uns_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            lsel_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rw_q    <= 1'b0;
            ra_q    <= '0;
            ov_q    <= 1'b0;
            orw_q   <= 1'b0;
            ora_q   <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            lsel_q  <= lsel_d;
            off_q   <= off_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            rw_q    <= rw_d;
            ra_q    <= ra_d;
            ov_q    <= ov_d;
            orw_q   <= orw_d;
            ora_q   <= ora_d;
            odata_q <= odata_d;
        end
    end

    assign input_ready_o  = (state_q == IDLE);
    assign wb_cyc_o       = (state_q != IDLE);
    assign wb_stb_o       = (state_q == REQUEST);
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_we_o        = we_q;
    assign output_valid_o = ov_q;
    assign reg_write_o    = orw_q;
    assign reg_addr_o     = ora_q;
    assign reg_data_o     = odata_q;

endmodule

// File: tb/tb_loadstore.sv
// Scoreboard bench for loadstore: expected write-back entries are queued at
// issue time and checked whenever output_valid_o pulses.
module tb_loadstore;

    logic        clk, rst;
    logic        input_ready_o, input_valid_i;
    logic [31:0] result_i, ls_write_data_i;
    logic        ls_enable_i, ls_write_i, ls_unsigned_load_i;
    logic [3:0]  ls_sel_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_stall_i;
    logic        output_valid_o, reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;

    typedef struct {
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   last_v = 0;
    int   prev_v = 0;

    loadstore dut (
        .clk_i(clk), .rst_i(rst),
        .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
        .result_i(result_i), .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i),
        .ls_unsigned_load_i(ls_unsigned_load_i), .ls_write_data_i(ls_write_data_i),
        .ls_sel_i(ls_sel_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
        .output_valid_o(output_valid_o), .reg_write_o(reg_write_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-back monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && output_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_reg_write", reg_write_o, e.rw);
                chk("wb_reg_addr",  reg_addr_o,  e.ra);
                chk("wb_reg_data",  reg_data_o,  e.data);
            end
            prev_v = last_v;
            last_v = cyc_n;
        end
    end

    task automatic issue(input logic [31:0] res, input logic en, input logic we,
                         input logic uns, input logic [31:0] wd, input logic [3:0] sel,
                         input logic rw, input logic [4:0] ra, input logic [31:0] exp_data);
        int n = 0;
        exp_t e;
        while (!input_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!input_ready_o) chk("ready_timeout", 0, 1);
        result_i = res; ls_enable_i = en; ls_write_i = we; ls_unsigned_load_i = uns;
        ls_write_data_i = wd; ls_sel_i = sel; reg_write_i = rw; reg_addr_i = ra;
        input_valid_i = 1'b1;
        e.rw = rw; e.ra = ra; e.data = exp_data;
        sb.push_back(e);
        @(posedge clk); #1;
        input_valid_i = 1'b0;
    endtask

    // Slave model: stall_n stalled cycles, then wait_n cycles before ack.
    task automatic serve(input int stall_n, input int wait_n, input logic [31:0] rdata,
                         input logic [31:0] eadr, input logic [3:0] esel,
                         input logic [31:0] edat, input logic ewe);
        int stb_cnt = 0;
        chk("bus_cyc",  wb_cyc_o, 1);
        chk("bus_adr",  wb_adr_o, eadr);
        chk("bus_sel",  wb_sel_o, esel);
        chk("bus_dat",  wb_dat_o, edat);
        chk("bus_we",   wb_we_o,  ewe);
        chk("bus_ready", input_ready_o, 0);
        for (int s = 0; s < stall_n; s++) begin
            if (wb_stb_o) stb_cnt++;
            wb_stall_i = 1'b1;
            @(posedge clk); #1;
        end
        if (wb_stb_o) stb_cnt++;
        chk("bus_stb_cycles", stb_cnt, stall_n + 1);
        wb_stall_i = 1'b0;
        wb_ack_i   = (wait_n == 0);
        wb_dat_i   = rdata;
        @(posedge clk); #1;
        if (wait_n > 0) begin
            chk("bus_stb_low", wb_stb_o, 0);
            chk("bus_hold_adr", wb_adr_o, eadr);
            wb_ack_i = 1'b0;
            for (int w = 1; w < wait_n; w++) begin
                chk("bus_wait_ready", input_ready_o, 0);
                @(posedge clk); #1;
            end
            wb_ack_i = 1'b1;
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hDEAD_BEEF;
        chk("bus_cyc_end", wb_cyc_o, 0);
    endtask

    initial begin
        rst = 1'b1; input_valid_i = 0; result_i = 0; ls_enable_i = 0; ls_write_i = 0;
        ls_unsigned_load_i = 0; ls_write_data_i = 0; ls_sel_i = 0; reg_write_i = 0;
        reg_addr_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_stall_i = 0;
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_outs", {wb_we_o, wb_sel_o, output_valid_o, reg_write_o, reg_addr_o}, 0);
        chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 0);
        chk("rst_reg_data", reg_data_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", input_ready_o, 1);

        // Pass-through
        issue(32'h1234_5678, 0, 0, 0, 0, 0, 1, 5'd5, 32'h1234_5678);
        chk("pt_no_cyc", wb_cyc_o, 0);
        chk("pt_valid", output_valid_o, 1);
        @(posedge clk); #1;
        chk("pt_valid_one", output_valid_o, 0);

        // Signed byte load, 2 waits
        issue(32'h0000_1003, 1, 0, 0, 0, 4'b0001, 1, 5'd3, 32'hFFFF_FF80);
        serve(0, 2, 32'h80FF_FFFF, 32'h0000_1000, 4'b1000, 32'h0, 0);
        // Unsigned half load
        issue(32'h0000_2002, 1, 0, 1, 0, 4'b0011, 1, 5'd4, 32'h0000_BEEF);
        serve(0, 1, 32'hBEEF_0000, 32'h0000_2000, 4'b1100, 32'h0, 0);
        // Half store with 3 stall cycles
        issue(32'h0000_3002, 1, 1, 0, 32'h0000_ABCD, 4'b0011, 0, 5'd7, 32'h0);
        serve(3, 1, 32'h0, 32'h0000_3000, 4'b1100, 32'hABCD_0000, 1);
        // Misaligned word load, immediate ack
        issue(32'h0000_4001, 1, 0, 0, 0, 4'b1111, 1, 5'd9, 32'h00AA_BBCC);
        serve(0, 0, 32'hAABB_CCDD, 32'h0000_4000, 4'b1110, 32'h0, 0);
        // Signed half load at offset 0
        issue(32'h0000_5000, 1, 0, 0, 0, 4'b0011, 1, 5'd10, 32'hFFFF_F00D);
        serve(1, 0, 32'h1234_F00D, 32'h0000_5000, 4'b0011, 32'h0, 0);
        // Unsigned byte load at offset 2
        issue(32'h0000_6006, 1, 0, 1, 0, 4'b0001, 1, 5'd11, 32'h0000_00C3);
        serve(0, 1, 32'h00C3_0000, 32'h0000_6004, 4'b0100, 32'h0, 0);
        // Misaligned word store at offset 3, high bytes discarded
        issue(32'h0000_7003, 1, 1, 0, 32'h1122_3344, 4'b1111, 1, 5'd12, 32'h0);
        serve(0, 0, 32'h0, 32'h0000_7000, 4'b1000, 32'h4400_0000, 1);

        // Stray ack while idle
        @(posedge clk); #1;
        wb_ack_i = 1'b1;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        chk("idle_ack_ignored", output_valid_o, 0);

        // Back-to-back: load then pass-through in the first idle cycle
        issue(32'h0000_8000, 1, 0, 0, 0, 4'b1111, 1, 5'd13, 32'hCAFE_F00D);
        serve(0, 1, 32'hCAFE_F00D, 32'h0000_8000, 4'b1111, 32'h0, 0);
        issue(32'h0000_0042, 0, 0, 0, 0, 0, 1, 5'd14, 32'h0000_0042);
        @(posedge clk); #1;
        chk("b2b_gap", last_v - prev_v, 1);

        // Reset while waiting for ack
        issue(32'h0000_9000, 1, 0, 0, 0, 4'b1111, 1, 5'd15, 32'h0);
        wb_stall_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_wait_state", {wb_cyc_o, wb_stb_o}, 2'b10);
        rst = 1'b1;
        #1;
        chk("abort_cyc", wb_cyc_o, 0);
        chk("abort_valid", output_valid_o, 0);
        chk("abort_reg_data", reg_data_o, 0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        chk("late_ack_ignored", output_valid_o, 0);
        chk("post_rst_ready", input_ready_o, 1);

        issue(32'hA5A5_0001, 0, 0, 0, 0, 0, 1, 5'd31, 32'hA5A5_0001);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/loadstore.md
LOADSTORE -- requirements
Module: loadstore

Interface
REQ-001 Clock/reset: one clock; reset is asynchronous and active-high.
REQ-002 clk_i  in  1  stage clock, all state on rising edge.
REQ-003 rst_i  in  1  asynchronous active-high reset.
REQ-004 input_ready_o  out  1 / input_valid_i  in  1  upstream handshake from execute stage; transfer when both high on a rising edge.
REQ-005 result_i  in  32  ALU result: effective address for memory ops, write-back data otherwise.
REQ-006 ls_enable_i, ls_write_i, ls_unsigned_load_i  in  1 each  memory op enable, store select, zero-extend load.
REQ-007 ls_write_data_i  in  32  store data, LSB-aligned; ls_sel_i  in  4  size mask, LSB-aligned (0001 byte, 0011 half, 1111 word).
REQ-008 reg_write_i  in  1 / reg_addr_i  in  5  write-back pass-through.
REQ-009 wb_adr_o  out  32, wb_dat_o  out  32, wb_sel_o  out  4, wb_we_o, wb_stb_o, wb_cyc_o  out  1  pipelined Wishbone B4 master.
REQ-010 wb_dat_i  in  32, wb_ack_i  in  1, wb_stall_i  in  1  Wishbone slave responses.
REQ-011 output_valid_o  out  1, reg_write_o  out  1, reg_addr_o  out  5, reg_data_o  out  32  write-back stage; no backpressure, sink always accepts.

Function
REQ-012 FSM states IDLE, REQUEST, WAIT_ACK; input_ready_o = 1 only in IDLE.
REQ-013 IDLE, transfer, ls_enable_i=0: next cycle output_valid_o=1 for one cycle, reg_data_o=result_i, reg_write_o/reg_addr_o from inputs; stay IDLE (1-cycle latency, back-to-back capable).
REQ-014 IDLE, transfer, ls_enable_i=1: latch all inputs, go REQUEST; next cycle wb_cyc_o=wb_stb_o=1.
REQ-015 wb_adr_o = {result[31:2],2'b00}; wb_sel_o = (ls_sel << result[1:0]) truncated to 4 bits; wb_dat_o = ls_write_data << 8*result[1:0]; wb_we_o = ls_write; all held stable while wb_cyc_o=1.
REQ-016 REQUEST: wb_stall_i=1 holds state; wb_stall_i=0 -> wb_stb_o low next cycle, go WAIT_ACK unless ack also seen.
REQ-017 wb_ack_i sampled in REQUEST (after stall=0) and WAIT_ACK; on ack: next cycle wb_cyc_o=0, output_valid_o=1 one cycle, state IDLE.
REQ-018 Load data: shifted = wb_dat_i >> 8*result[1:0]; sel 0001 -> byte, 0011 -> half, else word; sign-extend unless ls_unsigned_load; captured on ack edge into reg_data_o.
REQ-019 Stores: output_valid_o still pulses on completion; reg_data_o = 0; reg_write_o passes latched reg_write_i.
REQ-020 Misaligned access: no trap; bytes shifted beyond bit 31 / sel bit 3 discarded.
REQ-021 wb_ack_i while wb_cyc_o=0 ignored; only one outstanding transaction ever.
REQ-022 output_valid_o=0 in all cycles not named in REQ-013/017; reg_* hold last values when not valid.

Reset
REQ-023 rst_i asserted: immediately state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o=0, wb_sel_o=0, output_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_data_o=0, input_ready_o=1 after release.
REQ-024 Reset mid-transaction aborts bus cycle with no output_valid_o; late wb_ack_i afterwards ignored.

Verification
REQ-025 Pass-through: result_i=0x12345678, ls_enable=0, reg_write=1, reg_addr=5 -> next cycle output_valid_o=1, reg_data_o=0x12345678, reg_addr_o=5, no wb_cyc_o.
REQ-026 Signed byte load: result_i=0x1003, sel=0001, unsigned=0, wb_dat_i=0x80FFFFFF, ack after 2 waits -> wb_adr_o=0x1000, wb_sel_o=1000, reg_data_o=0xFFFFFF80.
REQ-027 Unsigned half load: result_i=0x2002, sel=0011, unsigned=1, wb_dat_i=0xBEEF0000 -> wb_sel_o=1100, reg_data_o=0x0000BEEF.
REQ-028 Half store: result_i=0x3002, write_data=0x0000ABCD, sel=0011, wb_stall_i=1 for 3 cycles -> stb held 4 cycles, wb_dat_o=0xABCD0000, wb_sel_o=1100, wb_we_o=1, output_valid_o pulse with reg_write_o=0.
REQ-029 Back-to-back: load completes, new pass-through accepted in first IDLE cycle -> two consecutive output_valid_o pulses separated by 1 cycle, input_ready_o=0 throughout bus cycle.
REQ-030 Reset mid-WAIT_ACK: assert rst_i -> wb_cyc_o=0 same cycle, subsequent wb_ack_i produces no output_valid_o.
